// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control unit: a Moore FSM that sequences fetch, decode,
// execute, memory and writeback for lw, sw, R-type, beq, addi and j. It drives
// every datapath enable and mux select and derives the ALU function code F.
module mips_multicycle_ctrl #(
  parameter bit ILLEGAL_CHECK = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  input  logic       Zero,
  output logic [2:0] F,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSrc,
  output logic       PCEn,
  output logic [3:0] state,
  output logic       err
);

  typedef enum logic [3:0] {
    StFetch   = 4'd0,
    StDecode  = 4'd1,
    StMemAdr  = 4'd2,
    StMemRd   = 4'd3,
    StMemWb   = 4'd4,
    StMemWr   = 4'd5,
    StExecute = 4'd6,
    StAluWb   = 4'd7,
    StBranch  = 4'd8,
    StAddiEx  = 4'd9,
    StAddiWb  = 4'd10,
    StJump    = 4'd11
  } state_e;

  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpJ     = 6'b000010;

  localparam logic [2:0] FAnd = 3'b000;
  localparam logic [2:0] FOr  = 3'b001;
  localparam logic [2:0] FAdd = 3'b010;
  localparam logic [2:0] FSub = 3'b110;
  localparam logic [2:0] FSlt = 3'b111;

  state_e     state_q, state_d;
  logic       err_q, err_d;
  logic       illegal;
  logic       funct_legal;
  logic [2:0] funct_f;
  logic       pc_write;
  logic       branch;

  // R-type Funct to ALU function, plus whether the Funct is one we support.
  always_comb begin
    funct_legal = 1'b1;
    funct_f     = FAdd;
    case (Funct)
      6'b100000: funct_f = FAdd;
      6'b100010: funct_f = FSub;
      6'b100100: funct_f = FAnd;
      6'b100101: funct_f = FOr;
      6'b101010: funct_f = FSlt;
      default:   funct_legal = 1'b0;
    endcase
  end

  // Next-state logic; illegal encodings are caught in DECODE so no write state is reached.
  always_comb begin
    state_d = StFetch;
    err_d   = err_q;
    illegal = 1'b0;
    case (state_q)
      StFetch:  state_d = StDecode;
      StDecode: begin
        case (Op)
          OpLw, OpSw: state_d = StMemAdr;
          OpRtype: begin
            if (funct_legal) state_d = StExecute;
            else             illegal = 1'b1;
          end
          OpBeq:   state_d = StBranch;
          OpAddi:  state_d = StAddiEx;
          OpJ:     state_d = StJump;
          default: illegal = 1'b1;
        endcase
        if (illegal && ILLEGAL_CHECK) err_d = 1'b1;
      end
      StMemAdr:  state_d = (Op == OpSw) ? StMemWr : StMemRd;
      StMemRd:   state_d = StMemWb;
      StExecute: state_d = StAluWb;
      StAddiEx:  state_d = StAddiWb;
      default:   state_d = StFetch;  // writeback/branch/jump states and unused encodings
    endcase
  end

  // State and sticky error register with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StFetch;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

  // Moore output decode; write enables are suppressed while reset is held.
  always_comb begin
    F        = FAdd;
    IorD     = 1'b0;
    MemWrite = 1'b0;
    IRWrite  = 1'b0;
    RegDst   = 1'b0;
    MemtoReg = 1'b0;
    RegWrite = 1'b0;
    ALUSrcA  = 1'b0;
    ALUSrcB  = 2'b00;
    PCSrc    = 2'b00;
    pc_write = 1'b0;
    branch   = 1'b0;
    case (state_q)
      StFetch: begin
        IRWrite  = 1'b1;
        pc_write = 1'b1;
        ALUSrcB  = 2'b01;
      end
      StDecode: ALUSrcB = 2'b11;
      StMemAdr: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      StMemRd: IorD = 1'b1;
      StMemWb: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
      end
      StMemWr: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
      end
      StExecute: begin
        ALUSrcA = 1'b1;
        F       = funct_f;
      end
      StAluWb: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
      end
      StBranch: begin
        ALUSrcA = 1'b1;
        F       = FSub;
        PCSrc   = 2'b01;
        branch  = 1'b1;
      end
      StAddiEx: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      StAddiWb: RegWrite = 1'b1;
      StJump: begin
        PCSrc    = 2'b10;
        pc_write = 1'b1;
      end
      default: ;
    endcase
    PCEn = pc_write | (branch & Zero);
    if (!rst_n) begin
      IRWrite  = 1'b0;
      PCEn     = 1'b0;
      MemWrite = 1'b0;
      RegWrite = 1'b0;
    end
  end

  assign state = state_q;
  assign err   = err_q;

endmodule
